// File: rtl/max_pooling_layer_if.sv
// Pixel stream into the pooling layer and pooled pixel stream out of it.
// The master side is the producer of input pixels and the consumer of pooled pixels.
interface max_pooling_layer_if #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4
);
   logic                      in_valid;
   logic [WIDTH*CHANNELS-1:0] input_data;
   logic [WIDTH*CHANNELS-1:0] output_data;
   logic                      valid;

   modport master (
      output in_valid,
      output input_data,
      input  output_data,
      input  valid
   );

   modport slave (
      input  in_valid,
      input  input_data,
      output output_data,
      output valid
   );
endinterface

// File: rtl/max_pooling_layer.sv
// Non-overlapping POOL_SIZE x POOL_SIZE max pooling over a raster-ordered,
// multi-channel pixel stream. Horizontal maxima are kept in a register and
// partial vertical maxima in a one-row buffer indexed by window column, so
// the upstream layer needs no line buffering. Pixels outside the last full
// window row/column are counted but ignored.
module max_pooling_layer #(
   parameter int WIDTH      = 16,
   parameter int CHANNELS   = 4,
   parameter int IMAGE_SIZE = 26,
   parameter int POOL_SIZE  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clk_en,
   max_pooling_layer_if.slave   bus
);
   localparam int P   = IMAGE_SIZE / POOL_SIZE;
   localparam int LIM = P * POOL_SIZE;
   localparam int DW  = WIDTH * CHANNELS;
   localparam int CW  = $clog2(IMAGE_SIZE + 1);
   localparam int OW  = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
   localparam int IW  = (P > 1) ? $clog2(P) : 1;

   localparam logic [CW-1:0] C_LAST = CW'(IMAGE_SIZE - 1);
   localparam logic [CW-1:0] C_LIM  = CW'(LIM);
   localparam logic [OW-1:0] O_LAST = OW'(POOL_SIZE - 1);

   logic [CW-1:0]  r_col;
   logic [CW-1:0]  r_row;
   logic [OW-1:0]  r_xoff;
   logic [OW-1:0]  r_yoff;
   logic [IW-1:0]  r_bidx;
   logic [DW-1:0]  r_hmax_p0;
   logic [DW-1:0]  r_out_p1;
   logic           r_vld_p1;
   logic [DW-1:0]  r_buf [0:P-1];

   logic           w_accept;
   logic           w_in_win;
   logic           w_first_x;
   logic           w_last_x;
   logic           w_first_y;
   logic           w_last_y;
   logic           w_done;
   logic [DW-1:0]  w_rd;
   logic [DW-1:0]  w_h;
   logic [DW-1:0]  w_v;

   function automatic logic signed [WIDTH-1:0] smax(input logic signed [WIDTH-1:0] a,
                                                    input logic signed [WIDTH-1:0] b);
      return (a > b) ? a : b;
   endfunction

   assign w_accept  = clk_en & bus.in_valid;
   assign w_in_win  = (r_col < C_LIM) && (r_row < C_LIM);
   assign w_first_x = (r_xoff == '0);
   assign w_last_x  = (r_xoff == O_LAST);
   assign w_first_y = (r_yoff == '0);
   assign w_last_y  = (r_yoff == O_LAST);
   assign w_done    = w_accept & w_in_win & w_last_x & w_last_y;
   assign w_rd      = r_buf[r_bidx];

   // Per-channel horizontal max (h) and the combined vertical max (v) for this pixel
   always_comb begin
      w_h = '0;
      w_v = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_h[c*WIDTH +: WIDTH] = w_first_x ? input_pix(c)
                                           : smax(r_hmax_p0[c*WIDTH +: WIDTH], input_pix(c));
         w_v[c*WIDTH +: WIDTH] = w_first_y ? w_h[c*WIDTH +: WIDTH]
                                           : smax(w_rd[c*WIDTH +: WIDTH], w_h[c*WIDTH +: WIDTH]);
      end
   end

   function automatic logic [WIDTH-1:0] input_pix(input int c);
      return bus.input_data[c*WIDTH +: WIDTH];
   endfunction

   // Raster position, window offsets and the running horizontal max
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col     <= '0;
         r_row     <= '0;
         r_xoff    <= '0;
         r_yoff    <= '0;
         r_bidx    <= '0;
         r_hmax_p0 <= '0;
      end else if (w_accept) begin
         r_hmax_p0 <= w_h;
         if (r_col == C_LAST) begin
            r_col  <= '0;
            r_xoff <= '0;
            r_bidx <= '0;
            if (r_row == C_LAST) begin
               r_row  <= '0;
               r_yoff <= '0;
            end else begin
               r_row  <= r_row + 1'b1;
               r_yoff <= (r_yoff == O_LAST) ? '0 : r_yoff + 1'b1;
            end
         end else begin
            r_col  <= r_col + 1'b1;
            r_xoff <= w_last_x ? '0 : r_xoff + 1'b1;
            if (w_last_x) r_bidx <= r_bidx + 1'b1;
         end
      end
   end

   // ---- stage boundary: pooled result registered one cycle after the completing pixel ----
   // Output register; valid lasts a single enabled cycle and holds while clk_en is low
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_p1 <= '0;
         r_vld_p1 <= 1'b0;
      end else if (clk_en) begin
         r_vld_p1 <= w_done;
         if (w_done) r_out_p1 <= w_v;
      end
   end

   // Row buffer of partial vertical maxima; always written at a window's first row before any read
   always_ff @(posedge clk) begin
      if (w_accept && w_in_win && w_last_x) r_buf[r_bidx] <= w_v;
   end

   assign bus.output_data = r_out_p1;
   assign bus.valid       = r_vld_p1;
endmodule

// File: tb/tb_max_pooling_layer.sv
// Bench for max_pooling_layer: four configurations share one stimulus bus,
// only the selected instance sees in_valid. Expected pooled pixels are queued
// with the cycle they must appear in; a monitor pops and compares them.
module tb_max_pooling_layer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        clk_en;
   logic        tb_vld;
   logic [15:0] tb_data;
   logic [1:0]  sel;

   typedef struct {
      logic [15:0] val;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   cyc   = 0;
   logic en_q  = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   max_pooling_layer_if #(.WIDTH(8), .CHANNELS(1)) ifA ();
   max_pooling_layer_if #(.WIDTH(8), .CHANNELS(2)) ifB ();
   max_pooling_layer_if #(.WIDTH(8), .CHANNELS(1)) ifT ();
   max_pooling_layer_if #(.WIDTH(8), .CHANNELS(1)) ifQ ();

   assign ifA.in_valid   = tb_vld && (sel == 2'd0);
   assign ifB.in_valid   = tb_vld && (sel == 2'd1);
   assign ifT.in_valid   = tb_vld && (sel == 2'd2);
   assign ifQ.in_valid   = tb_vld && (sel == 2'd3);
   assign ifA.input_data = tb_data[7:0];
   assign ifB.input_data = tb_data;
   assign ifT.input_data = tb_data[7:0];
   assign ifQ.input_data = tb_data[7:0];

   max_pooling_layer #(.WIDTH(8), .CHANNELS(1), .IMAGE_SIZE(4), .POOL_SIZE(2)) uA (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(ifA));
   max_pooling_layer #(.WIDTH(8), .CHANNELS(2), .IMAGE_SIZE(2), .POOL_SIZE(2)) uB (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(ifB));
   max_pooling_layer #(.WIDTH(8), .CHANNELS(1), .IMAGE_SIZE(5), .POOL_SIZE(2)) uT (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(ifT));
   max_pooling_layer #(.WIDTH(8), .CHANNELS(1), .IMAGE_SIZE(6), .POOL_SIZE(3)) uQ (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(ifQ));

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      en_q <= clk_en;
   end

   task automatic mon(input string nm, input logic [15:0] got);
      exp_t e;
      n_cmp++;
      if (q.size() == 0) begin
         n_bad++;
         $display("FAIL %s unexpected output got=%h at cycle %0d required=none", nm, got, cyc);
      end else begin
         e = q.pop_front();
         if (got !== e.val || cyc != e.cyc) begin
            n_bad++;
            $display("FAIL %s output got=%h at cycle %0d required=%h at cycle %0d",
                     nm, got, cyc, e.val, e.cyc);
         end
      end
   endtask

   // A new pooled pixel is one seen after an edge taken with clk_en high
   always @(negedge clk) begin
      if (en_q) begin
         if (ifA.valid) mon("basic", {8'h00, ifA.output_data});
         if (ifB.valid) mon("signed", ifB.output_data);
         if (ifT.valid) mon("trunc", {8'h00, ifT.output_data});
         if (ifQ.valid) mon("pool3", {8'h00, ifQ.output_data});
      end
   end

   task automatic chk_eq(input string nm, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h required=%h", nm, got, exp);
      end
   endtask

   task automatic px(input logic [15:0] d, input bit e, input logic [15:0] ev);
      clk_en  = 1'b1;
      tb_vld  = 1'b1;
      tb_data = d;
      if (e) q.push_back('{ev, cyc + 1});
      @(negedge clk);
      tb_vld  = 1'b0;
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         clk_en  = 1'b1;
         tb_vld  = 1'b0;
         tb_data = 16'($urandom_range(0, 255));
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] sgn [8];
      sgn = '{16'h0AFB, 16'h80FD, 16'h7FF9, 16'h00FE,
              16'hFF03, 16'hFEFF, 16'hFDF8, 16'hFC02};
      rst_n   = 1'b0;
      clk_en  = 1'b0;
      tb_vld  = 1'b0;
      tb_data = '0;
      sel     = 2'd0;
      repeat (2) @(negedge clk);
      chk_eq("rst_valid_A", {15'd0, ifA.valid}, 16'd0);
      chk_eq("rst_data_A", {8'h00, ifA.output_data}, 16'd0);
      chk_eq("rst_valid_B", {15'd0, ifB.valid}, 16'd0);
      chk_eq("rst_data_B", ifB.output_data, 16'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // basic 4x4, pool 2
      sel = 2'd0;
      for (int p = 1; p <= 16; p++) px(16'(p), p inside {6, 8, 14, 16}, 16'(p));
      gap(3);

      // signed, two channels, two single-window frames
      sel = 2'd1;
      for (int i = 0; i < 8; i++)
         px(sgn[i], (i == 3) || (i == 7), (i == 3) ? 16'h7FFE : 16'hFF03);
      gap(3);

      // truncation 5x5, two back-to-back frames
      sel = 2'd2;
      for (int f = 0; f < 2; f++)
         for (int p = 1; p <= 25; p++) px(16'(p), p inside {7, 9, 17, 19}, 16'(p));
      gap(3);

      // pool 3 on 6x6
      sel = 2'd3;
      for (int p = 1; p <= 36; p++) px(16'(p), p inside {15, 18, 33, 36}, 16'(p));
      gap(3);

      // stalls: random in_valid gaps, clk_en low for 3 cycles right after output 6
      sel = 2'd0;
      for (int p = 1; p <= 16; p++) begin
         if (p == 7) begin
            clk_en  = 1'b0;
            tb_vld  = 1'b1;
            tb_data = 16'd7;
            for (int k = 0; k < 3; k++) begin
               @(negedge clk);
               chk_eq("hold_valid", {15'd0, ifA.valid}, 16'd1);
               chk_eq("hold_data", {8'h00, ifA.output_data}, 16'd6);
            end
         end else if ($urandom_range(0, 1) == 1) begin
            gap(1);
         end
         px(16'(p), p inside {6, 8, 14, 16}, 16'(p));
      end
      gap(3);

      // asynchronous reset after pixel 7, then a fresh frame
      for (int p = 1; p <= 7; p++) px(16'(p), p == 6, 16'd6);
      #2 rst_n = 1'b0;
      #1;
      chk_eq("async_rst_valid", {15'd0, ifA.valid}, 16'd0);
      chk_eq("async_rst_data", {8'h00, ifA.output_data}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int p = 1; p <= 16; p++) px(16'(p), p inside {6, 8, 14, 16}, 16'(p));
      gap(5);

      chk_eq("pending_expected", 16'(q.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/max_pooling_layer.md
Name: max_pooling_layer

Overview:
- Downstream stage of the convolutional layer. Consumes its raster-ordered multi-channel output stream, qualified by that layer's valid.
- Performs non-overlapping POOL_SIZE x POOL_SIZE max pooling per channel.
- Emits one pooled pixel per window, in raster order, to the next layer.
- Holds partial vertical maxima in an internal row buffer, so the input needs no line buffering upstream.

Parameters:
- WIDTH, 16, bits per channel sample; signed two's complement.
- CHANNELS, 4, number of channels; equals the upstream CHANNELS_OUT.
- IMAGE_SIZE, 26, side length of the square input feature map, in pixels.
- POOL_SIZE, 2, window side and stride. Legal range 2..IMAGE_SIZE.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clk_en  input  1  global enable; when low, all state holds.
- in_valid  input  1  input_data carries a valid pixel; driven by the upstream valid.
- input_data  input  WIDTH*CHANNELS  one pixel; channel c occupies bits [WIDTH*c +: WIDTH].
- output_data  output  WIDTH*CHANNELS  pooled pixel, same channel packing.
- valid  output  1  output_data holds a new pooled pixel.

Behaviour:
- Accept condition: a pixel is accepted on a rising clk edge with rst_n=1, clk_en=1 and in_valid=1. No other condition accepts input, and no backpressure exists.
- Position counters: col and row, each 0..IMAGE_SIZE-1.
  - col increments on each accepted pixel.
  - At col=IMAGE_SIZE-1, col wraps to 0 and row increments.
  - At row=IMAGE_SIZE-1, col=IMAGE_SIZE-1, both wrap to 0 (frame end). The next accepted pixel starts a new frame; no idle cycle is needed.
- Derived indices: P = IMAGE_SIZE / POOL_SIZE (integer division).
  - Pixels with col >= P*POOL_SIZE or row >= P*POOL_SIZE are accepted and counted, but ignored for pooling (edge truncation).
- Horizontal stage, per channel register hmax:
  - first column of a window (col % POOL_SIZE == 0): hmax <= pixel.
  - otherwise: hmax <= max(hmax, pixel), signed compare.
- Row buffer: P entries x WIDTH*CHANNELS, indexed by col / POOL_SIZE. Let h = max(hmax, pixel), or the pixel itself if POOL_SIZE==1 along x. At the last column of a window:
  - first row of a window: buf[idx] <= h.
  - middle rows: buf[idx] <= max(buf[idx], h).
  - last row of a window: output_data <= max(buf[idx], h) per channel; valid <= 1.
- valid:
  - valid is 1 for exactly one clk_en-high cycle per pooled pixel.
  - On the next clk_en-high edge it clears unless a new result is produced on that edge.
  - With clk_en low, valid and output_data hold.
- Latency: output registered 1 cycle after the accepted pixel completing the window.
- Throughput: one pooled pixel per POOL_SIZE accepted pixels at most. Output count per frame is exactly P*P.
- in_valid gaps: counters and hmax hold; pooling result identical to a gap-free stream.
- Reset (asynchronous, any time including mid-frame): col, row, hmax, output_data <= 0; valid <= 0. Row buffer contents need no reset; they are always written before being read. The first accepted pixel after reset is treated as (row 0, col 0).
- Widths: no arithmetic growth; output WIDTH equals input WIDTH. Comparison is signed; on ties the value is identical, so no tie-break is needed.
- Row buffer storage: inferable as RAM; one read and one write per accepted pixel, same address.

Test Plan:
- Basic 2x2:
  - Config: WIDTH=8, CHANNELS=1, IMAGE_SIZE=4, POOL_SIZE=2.
  - Stimulus: raster input 1..16 at in_valid=1 every cycle.
  - Required: valid pulses after pixels 6, 8, 14, 16, with outputs 6, 8, 14, 16.
- Signed and multi-channel:
  - Config: CHANNELS=2; ch0 window {-5,-3,-7,-2}, ch1 window {10,-128,127,0}.
  - Required: ch0 output -2 (0xFE); ch1 output 127.
- Truncation:
  - Config: IMAGE_SIZE=5, POOL_SIZE=2, input 1..25.
  - Required: exactly 4 outputs, values 7, 9, 17, 19. Row 4 and column 4 are ignored. A second frame yields identical values with no idle gap.
- Stall handling:
  - Stimulus: the basic test with in_valid randomly low ~50%, and clk_en low for 3 cycles mid-window.
  - Required: same output sequence 6, 8, 14, 16. valid and output_data hold while clk_en is low.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 asynchronously after pixel 7, then restart a fresh frame 1..16.
  - Required: valid=0 and output_data=0 immediately on reset; outputs then 6, 8, 14, 16, with no stale maxima.
- Pool 3:
  - Config: IMAGE_SIZE=6, POOL_SIZE=3, input 1..36.
  - Required: outputs 15, 18, 33, 36, each one cycle after the completing pixel.
